mem_arbiter: RTL and testbench

- Shares one external memory bus between the instruction-fetch port and the MEM stage's data port.
- Sequences each access as a multi-cycle, ack-terminated bus transaction.
- Raises stall requests towards the pipeline controller until every pending access in the current pipeline cycle has been served.
- Sits between the IF/MEM stages and the single-port memory/bus slave.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-bus arbiter.
// Holds the FSM encoding and the legacy pipeline constants.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle    = 2'b00,
        ArbBusyMem = 2'b01,
        ArbBusyIf  = 2'b10
    } arb_state_e;

    localparam logic [3:0]  SEL_FULL_WORD = 4'b1111;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// External single-port memory bus: the arbiter is the master, the memory/bus slave the slave.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_ack_i;

    modport master (
        output bus_req_o,
        output bus_we_o,
        output bus_sel_o,
        output bus_addr_o,
        output bus_wdata_o,
        input  bus_rdata_i,
        input  bus_ack_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_we_o,
        input  bus_sel_o,
        input  bus_addr_o,
        input  bus_wdata_o,
        output bus_rdata_i,
        output bus_ack_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one external memory bus between the instruction-fetch port and the MEM-stage data port.
// MEM wins ties; each port's stall stays up until its access has been served this pipeline cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_stallreq_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_stallreq_o,
    mem_arbiter_if.master     bus
);

    arb_state_e        state_q, state_nx;
    logic              req_q, req_nx;
    logic              we_q, we_nx;
    logic [3:0]        sel_q, sel_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic [DATA_W-1:0] if_data_q, if_data_nx;
    logic [DATA_W-1:0] mem_data_q, mem_data_nx;
    logic              if_done_q, if_done_nx;
    logic              mem_done_q, mem_done_nx;
    logic              flushed_q, flushed_nx;

    logic              if_pend;
    logic              mem_pend;
    logic              advance;

    assign if_pend  = (if_ce_i == CHIP_ENABLE) & ~if_done_q;
    assign mem_pend = (mem_ce_i == CHIP_ENABLE) & ~mem_done_q;
    // Both stalls low means the pipeline moves on this edge: start a fresh service round.
    assign advance  = ~if_pend & ~mem_pend;

    assign if_stallreq_o  = if_pend & (rst != RST_ENABLE);
    assign mem_stallreq_o = mem_pend & (rst != RST_ENABLE);

    assign bus.bus_req_o   = req_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_sel_o   = sel_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign if_data_o       = if_data_q;
    assign mem_data_o      = mem_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ArbIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            mem_data_q <= '0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            flushed_q  <= 1'b0;
        end else begin
            state_q    <= state_nx;
            req_q      <= req_nx;
            we_q       <= we_nx;
            sel_q      <= sel_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            if_data_q  <= if_data_nx;
            mem_data_q <= mem_data_nx;
            if_done_q  <= if_done_nx;
            mem_done_q <= mem_done_nx;
            flushed_q  <= flushed_nx;
        end
    end

    always_comb begin
        state_nx    = state_q;
        req_nx      = req_q;
        we_nx       = we_q;
        sel_nx      = sel_q;
        addr_nx     = addr_q;
        wdata_nx    = wdata_q;
        if_data_nx  = if_data_q;
        mem_data_nx = mem_data_q;
        if_done_nx  = if_done_q;
        mem_done_nx = mem_done_q;
        flushed_nx  = flushed_q;

        if (advance) begin
            if_done_nx  = 1'b0;
            mem_done_nx = 1'b0;
        end
        if (flush_i) begin
            if_done_nx = 1'b0;
        end

        case (state_q)
            ArbIdle: begin
                flushed_nx = 1'b0;
                if (mem_pend) begin
                    req_nx   = 1'b1;
                    we_nx    = mem_we_i;
                    sel_nx   = mem_sel_i;
                    addr_nx  = mem_addr_i;
                    wdata_nx = mem_data_i;
                    state_nx = ArbBusyMem;
                end else if (if_pend) begin
                    req_nx   = 1'b1;
                    we_nx    = 1'b0;
                    sel_nx   = SEL_FULL_WORD;
                    addr_nx  = if_addr_i;
                    state_nx = ArbBusyIf;
                end
            end
            ArbBusyMem: begin
                if (bus.bus_ack_i) begin
                    req_nx      = 1'b0;
                    mem_done_nx = 1'b1;
                    state_nx    = ArbIdle;
                    if (!we_q) begin
                        mem_data_nx = bus.bus_rdata_i;
                    end
                end
            end
            ArbBusyIf: begin
                // A flush anywhere in the fetch makes its result stale; the fetch is reissued.
                if (flush_i) begin
                    flushed_nx = 1'b1;
                end
                if (bus.bus_ack_i) begin
                    req_nx   = 1'b0;
                    state_nx = ArbIdle;
                    if (!(flush_i || flushed_q)) begin
                        if_done_nx = 1'b1;
                        if_data_nx = bus.bus_rdata_i;
                    end
                end
            end
            default: begin
                req_nx   = 1'b0;
                state_nx = ArbIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized pipeline cycles against a
// transaction-timeline reference model (bus slave acks are scheduled by the model).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        if_ce_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] mem_data_o;
    logic        mem_stallreq_o;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .if_stallreq_o  (if_stallreq_o),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .mem_data_o     (mem_data_o),
        .mem_stallreq_o (mem_stallreq_o),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ifce;
        bit          memce;
        bit          we;
        bit          flush;
        logic [3:0]  sel;
        logic [31:0] ifaddr;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [31:0] ifrd;
        logic [31:0] ifrd2;
        logic [31:0] memrd;
        int          dmem;
        int          dif;
        int          dif2;
        int          foff;
    } req_t;

    typedef struct {
        int          start;
        int          ack;
        bit          is_if;
        bit          we;
        bit          flushed;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] if_exp = '0;
    logic [31:0] mem_exp = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic req_t blank();
        req_t r;
        r.ifce = 0; r.memce = 0; r.we = 0; r.flush = 0;
        r.sel = 4'hF; r.ifaddr = '0; r.maddr = '0; r.wdata = '0;
        r.ifrd = '0; r.ifrd2 = '0; r.memrd = '0;
        r.dmem = 1; r.dif = 1; r.dif2 = 1; r.foff = 0;
        return r;
    endfunction

    // One pipeline cycle: requests appear at t0 (arbiter idle), MEM first then IF,
    // each transaction starts one cycle after the arbiter is idle and a stall drops the
    // cycle after its last ack. Ends on the cycle where both stalls are low.
    task automatic run_pcycle(input req_t r);
        txn_t q[$];
        txn_t t;
        int   t0;
        int   nxt;
        int   if_end;
        int   mem_end;
        int   tend;
        int   fl_c;
        t0 = cyc; nxt = t0 + 1; if_end = -1; mem_end = -1; fl_c = -1;
        if (r.memce) begin
            t.start = nxt; t.ack = nxt + r.dmem - 1; t.is_if = 0; t.we = r.we;
            t.flushed = 0; t.sel = r.sel; t.addr = r.maddr; t.wdata = r.wdata; t.rdata = r.memrd;
            q.push_back(t);
            mem_end = t.ack; nxt = t.ack + 2;
        end
        if (r.ifce) begin
            t.start = nxt; t.ack = nxt + r.dif - 1; t.is_if = 1; t.we = 0;
            t.flushed = r.flush; t.sel = 4'hF; t.addr = r.ifaddr; t.wdata = '0; t.rdata = r.ifrd;
            q.push_back(t);
            nxt = t.ack + 2;
            if (r.flush) begin
                fl_c = t.start + (r.foff % r.dif);
                t.start = nxt; t.ack = nxt + r.dif2 - 1; t.flushed = 0; t.rdata = r.ifrd2;
                q.push_back(t);
            end
            if_end = t.ack;
        end
        tend = (q.size() == 0) ? t0 : q[q.size()-1].ack + 1;

        for (int c = t0; c <= tend; c++) begin
            int          cur;
            bit          ackc;
            logic [31:0] rd;
            cur = -1; ackc = 0; rd = $urandom;
            foreach (q[k]) begin
                if (c >= q[k].start && c <= q[k].ack) cur = k;
                if (c == q[k].ack) begin
                    ackc = 1;
                    rd = q[k].rdata;
                end
                if (c == q[k].ack + 1 && !q[k].we && !q[k].flushed) begin
                    if (q[k].is_if) if_exp = q[k].rdata;
                    else mem_exp = q[k].rdata;
                end
            end
            if (cur < 0 && $urandom_range(0, 3) == 0) ackc = 1;
            if_ce_i = r.ifce; if_addr_i = r.ifaddr;
            mem_ce_i = r.memce; mem_we_i = r.we; mem_sel_i = r.sel;
            mem_addr_i = r.maddr; mem_data_i = r.wdata;
            flush_i = (c == fl_c);
            bus.bus_ack_i = ackc; bus.bus_rdata_i = rd;
            #1;
            chk("bus_req", 32'(bus.bus_req_o), 32'(cur >= 0));
            if (cur >= 0) begin
                chk("bus_addr", bus.bus_addr_o, q[cur].addr);
                chk("bus_we", 32'(bus.bus_we_o), 32'(q[cur].we));
                chk("bus_sel", 32'(bus.bus_sel_o), 32'(q[cur].sel));
                if (!q[cur].is_if) chk("bus_wdata", bus.bus_wdata_o, q[cur].wdata);
            end
            chk("if_stall", 32'(if_stallreq_o), 32'(r.ifce && c <= if_end));
            chk("mem_stall", 32'(mem_stallreq_o), 32'(r.memce && c <= mem_end));
            chk("if_data", if_data_o, if_exp);
            chk("mem_data", mem_data_o, mem_data_o === mem_data_o ? mem_exp : mem_exp);
            step();
        end
        flush_i = 1'b0;
        bus.bus_ack_i = 1'b0;
    endtask

    initial begin
        req_t r;
        bus.bus_ack_i = 1'b0;
        bus.bus_rdata_i = '0;
        if_ce_i = 1'b1;
        mem_ce_i = 1'b1;
        step();
        step();
        chk("rst_if_stall", 32'(if_stallreq_o), 32'd0);
        chk("rst_mem_stall", 32'(mem_stallreq_o), 32'd0);
        chk("rst_bus_req", 32'(bus.bus_req_o), 32'd0);
        chk("rst_bus_addr", bus.bus_addr_o, 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);
        rst = 1'b0;

        r = blank(); r.ifce = 1; r.ifaddr = 32'h0000_0010; r.dif = 3; r.ifrd = 32'h2401_0005;
        run_pcycle(r);
        chk("if_only_data", if_data_o, 32'h2401_0005);

        r = blank(); r.memce = 1; r.we = 1; r.sel = 4'b0100; r.maddr = 32'h0000_0102;
        r.wdata = 32'h5A5A_5A5A; r.dmem = 2; r.memrd = 32'hFFFF_0000;
        run_pcycle(r);
        chk("store_keeps_mem_data", mem_data_o, 32'h0);

        r = blank(); r.ifce = 1; r.ifaddr = 32'h0000_0020; r.ifrd = 32'h1111_2222; r.dif = 2;
        r.memce = 1; r.maddr = 32'h0000_0200; r.memrd = 32'h3333_4444; r.dmem = 2;
        run_pcycle(r);
        chk("simul_if_data", if_data_o, 32'h1111_2222);
        chk("simul_mem_data", mem_data_o, 32'h3333_4444);

        r = blank(); r.ifce = 1; r.ifaddr = 32'h0000_0024; r.ifrd = 32'h5555_6666; r.dif = 6;
        r.memce = 1; r.maddr = 32'h0000_0200; r.memrd = 32'h7777_8888; r.dmem = 1;
        run_pcycle(r);

        r = blank(); r.ifce = 1; r.ifaddr = 32'h0000_0028; r.dif = 3; r.flush = 1; r.foff = 1;
        r.ifrd = 32'hDEAD_BEEF; r.ifrd2 = 32'h0BAD_F00D; r.dif2 = 2;
        run_pcycle(r);
        chk("flush_refetch_data", if_data_o, 32'h0BAD_F00D);

        // Reset while a MEM load is on the bus.
        if_ce_i = 1'b0; mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF;
        mem_addr_i = 32'h0000_0300; mem_data_i = 32'h0;
        step();
        step();
        chk("pre_rst_bus_req", 32'(bus.bus_req_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_bus_req", 32'(bus.bus_req_o), 32'd0);
        chk("midrst_bus_we", 32'(bus.bus_we_o), 32'd0);
        chk("midrst_bus_sel", 32'(bus.bus_sel_o), 32'd0);
        chk("midrst_bus_addr", bus.bus_addr_o, 32'd0);
        chk("midrst_if_data", if_data_o, 32'd0);
        chk("midrst_mem_data", mem_data_o, 32'd0);
        chk("midrst_mem_stall", 32'(mem_stallreq_o), 32'd0);
        if_exp = '0;
        mem_exp = '0;
        step();
        rst = 1'b0;
        r = blank(); r.memce = 1; r.maddr = 32'h0000_0300; r.memrd = 32'h9999_AAAA; r.dmem = 2;
        run_pcycle(r);
        chk("after_rst_mem_data", mem_data_o, 32'h9999_AAAA);

        for (int n = 0; n < 300; n++) begin
            r = blank();
            r.ifce   = ($urandom_range(0, 3) != 0);
            r.memce  = ($urandom_range(0, 1) != 0);
            r.we     = ($urandom_range(0, 1) != 0);
            r.sel    = 4'($urandom_range(1, 15));
            r.ifaddr = $urandom & 32'hFFFF_FFFC;
            r.maddr  = $urandom;
            r.wdata  = $urandom;
            r.ifrd   = $urandom;
            r.ifrd2  = $urandom;
            r.memrd  = $urandom;
            r.dmem   = $urandom_range(1, 5);
            r.dif    = $urandom_range(1, 5);
            r.dif2   = $urandom_range(1, 4);
            r.flush  = r.ifce && ($urandom_range(0, 4) == 0);
            r.foff   = $urandom_range(0, 7);
            run_pcycle(r);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
